// File: rtl/div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_W     = 8;
  localparam int DIV_CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract
// the divisor if it fits, and report the resulting quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0]   rem_sh;
  logic [W-1:0] diff;
  logic         ge;

  // The incoming remainder is always below the divisor, so the shifted value
  // is below 2*B and the difference fits back into W bits whenever ge is set.
  assign rem_sh  = {rem_i, dvd_bit_i};
  assign ge      = (rem_sh >= {1'b0, dvs_i});
  assign diff    = rem_sh[W-1:0] - dvs_i;
  assign rem_o   = ge ? diff : rem_sh[W-1:0];
  assign q_bit_o = ge;

endmodule

// File: rtl/div8u_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Result is packed as {remainder, quotient} on O with a divide-by-zero flag.
module div8u_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] O,
  output logic           dz
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  div_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic          dz_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [W-1:0]  rem_d;
  logic          q_bit_d;

  div_step #(.W(W)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  // Handshake flags are registered alongside the state so that no output
  // depends combinationally on in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            dvd_q      <= A;
            dvs_q      <= B;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            dz_q       <= (B == '0);
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[W-2:0], q_bit_d};
          dvd_q <= {dvd_q[W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign O         = {rem_q, quo_q};
  assign dz        = dz_q;

endmodule
